// File: rtl/cr_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cr_cpu_pkg
// Description : Shared definitions for the decode/sequencing stage.
//               Provides opcode encodings, the decoder state enum, default
//               parameter values and the branch target helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cr_cpu_pkg;

    // Opcode encodings (instr[15:12]); 0x7-0xF are undefined
    localparam logic [3:0] c_op_nop   = 4'h0;
    localparam logic [3:0] c_op_alu   = 4'h1;
    localparam logic [3:0] c_op_load  = 4'h2;
    localparam logic [3:0] c_op_store = 4'h3;
    localparam logic [3:0] c_op_jmp   = 4'h4;
    localparam logic [3:0] c_op_bz    = 4'h5;
    localparam logic [3:0] c_op_bnz   = 4'h6;

    localparam logic [15:0] c_halt_word_default   = 16'hFFFF;
    localparam int          c_count_width_default = 16;

    typedef enum logic [1:0] {
        ST_FLUSH    = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    // PC-relative target with a signed 8-bit offset, 16-bit wrap-around
    function automatic logic [15:0] branch_target(input logic [15:0] pc,
                                                  input logic [7:0]  offset);
        return pc + {{8{offset[7]}}, offset};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decoder_if
// Description : Bundle of fetch, datapath-control and memory-handshake
//               signals between the decoder and the rest of the core.
//               Signal prefixes are from the decoder's point of view.
//   master : decoder side (consumes fetch/datapath status, drives controls)
//   slave  : core side (drives fetch/datapath status, consumes controls)
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_decoder_if #(
    parameter int COUNT_WIDTH = 16
);
    logic [15:0]            i_instruction;
    logic [15:0]            i_pc_addr;
    logic                   i_zero;
    logic                   i_mem_ready;
    logic                   o_pc_inc;
    logic                   o_pc_load;
    logic [15:0]            o_pc_addr;
    logic [3:0]             o_alu_op;
    logic [7:0]             o_operand;
    logic                   o_reg_we;
    logic                   o_mem_req;
    logic                   o_mem_we;
    logic                   o_illegal;
    logic                   o_halted;
    logic [COUNT_WIDTH-1:0] o_retired;
    logic [COUNT_WIDTH-1:0] o_bubbles;

    modport master (
        input  i_instruction, i_pc_addr, i_zero, i_mem_ready,
        output o_pc_inc, o_pc_load, o_pc_addr, o_alu_op, o_operand,
               o_reg_we, o_mem_req, o_mem_we, o_illegal, o_halted,
               o_retired, o_bubbles
    );

    modport slave (
        output i_instruction, i_pc_addr, i_zero, i_mem_ready,
        input  o_pc_inc, o_pc_load, o_pc_addr, o_alu_op, o_operand,
               o_reg_we, o_mem_req, o_mem_we, o_illegal, o_halted,
               o_retired, o_bubbles
    );
endinterface
`default_nettype wire

// File: rtl/decoder_perf_counter.sv
`default_nettype none
// ============================================================================
// Module      : decoder_perf_counter
// Description : Saturating event counter with enable.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset, clears the count
//   i_en    : count one event this cycle
//   o_count : current count, sticks at all-ones
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_perf_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    input  wire logic             i_en,
    output logic      [WIDTH-1:0] o_count
);
    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (i_en && (r_count_q != '1)) begin
            w_count_d = r_count_q + c_one;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_count = r_count_q;

endmodule
`default_nettype wire

// File: rtl/instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decoder
// Description : Decode/sequencing stage behind the program counter. Decodes
//               the fetched word into single-cycle datapath controls, steers
//               the PC (increment / load target), discards the stale word
//               after reset and after every PC load, and stalls fetch while
//               a data-memory access is outstanding.
//   i_clk   : core clock, rising edge
//   i_rst_n : asynchronous active-low reset; forces every output to 0
//   bus     : instruction_decoder_if.master (fetch inputs, controls,
//             memory handshake, performance counters)
// Build option : INSTR_DECODER_PERF_EN enables the retired/bubble counters;
//                otherwise o_retired and o_bubbles are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_decoder
    import cr_cpu_pkg::*;
#(
    parameter logic [15:0] HALT_WORD   = c_halt_word_default,
    parameter int          COUNT_WIDTH = c_count_width_default
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    instruction_decoder_if.master bus
);

    state_t      r_state_q;
    state_t      w_state_d;
    logic [15:0] r_instr_q;
    logic [15:0] w_instr_d;

    logic [3:0]  w_opcode;
    logic [3:0]  w_wait_opcode;
    logic [15:0] w_target;

    logic        w_pc_inc;
    logic        w_pc_load;
    logic [15:0] w_pc_addr;
    logic [3:0]  w_alu_op;
    logic [7:0]  w_operand;
    logic        w_reg_we;
    logic        w_mem_req;
    logic        w_mem_we;
    logic        w_illegal;
    logic        w_halted;
    logic        w_retire_en;
    logic        w_bubble_en;

    assign w_opcode      = bus.i_instruction[15:12];
    assign w_wait_opcode = r_instr_q[15:12];
    assign w_target      = branch_target(bus.i_pc_addr, bus.i_instruction[7:0]);

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state_q;
        w_instr_d   = r_instr_q;
        w_pc_inc    = 1'b0;
        w_pc_load   = 1'b0;
        w_pc_addr   = '0;
        w_alu_op    = '0;
        w_operand   = '0;
        w_reg_we    = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_illegal   = 1'b0;
        w_halted    = 1'b0;
        w_retire_en = 1'b0;
        w_bubble_en = 1'b0;

        case (r_state_q)
            // Stale word from the fetch path: drop it, keep fetch moving
            ST_FLUSH: begin
                w_pc_inc    = 1'b1;
                w_bubble_en = 1'b1;
                w_state_d   = ST_EXEC;
            end

            ST_EXEC: begin
                // Halt word is checked first so it overrides its opcode field
                if (bus.i_instruction == HALT_WORD) begin
                    w_state_d = ST_HALT;
                end else begin
                    w_alu_op  = bus.i_instruction[11:8];
                    w_operand = bus.i_instruction[7:0];
                    case (w_opcode)
                        c_op_nop: begin
                            w_pc_inc    = 1'b1;
                            w_retire_en = 1'b1;
                        end
                        c_op_alu: begin
                            w_reg_we    = 1'b1;
                            w_pc_inc    = 1'b1;
                            w_retire_en = 1'b1;
                        end
                        c_op_load, c_op_store: begin
                            w_mem_req = 1'b1;
                            w_mem_we  = (w_opcode == c_op_store);
                            if (bus.i_mem_ready) begin
                                w_reg_we    = (w_opcode == c_op_load);
                                w_pc_inc    = 1'b1;
                                w_retire_en = 1'b1;
                            end else begin
                                // Fetch input will change under us; hold the word
                                w_instr_d = bus.i_instruction;
                                w_state_d = ST_MEM_WAIT;
                            end
                        end
                        c_op_jmp, c_op_bz, c_op_bnz: begin
                            w_pc_addr   = w_target;
                            w_retire_en = 1'b1;
                            if ((w_opcode == c_op_jmp) ||
                                ((w_opcode == c_op_bz)  &&  bus.i_zero) ||
                                ((w_opcode == c_op_bnz) && !bus.i_zero)) begin
                                w_pc_load = 1'b1;
                                w_state_d = ST_FLUSH;
                            end else begin
                                w_pc_inc = 1'b1;
                            end
                        end
                        default: begin
                            // Undefined opcode executes as a NOP
                            w_alu_op    = '0;
                            w_operand   = '0;
                            w_illegal   = 1'b1;
                            w_pc_inc    = 1'b1;
                            w_retire_en = 1'b1;
                        end
                    endcase
                end
            end

            // Controls come from the latched word; fetch is frozen on it
            ST_MEM_WAIT: begin
                w_alu_op    = r_instr_q[11:8];
                w_operand   = r_instr_q[7:0];
                w_mem_req   = 1'b1;
                w_mem_we    = (w_wait_opcode == c_op_store);
                w_bubble_en = 1'b1;
                if (bus.i_mem_ready) begin
                    w_reg_we    = (w_wait_opcode == c_op_load);
                    w_pc_inc    = 1'b1;
                    w_retire_en = 1'b1;
                    w_state_d   = ST_EXEC;
                end
            end

            ST_HALT: begin
                w_halted = 1'b1;
            end

            default: begin
                w_state_d = ST_FLUSH;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q <= ST_FLUSH;
            r_instr_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_instr_q <= w_instr_d;
        end
    end

    // Reset gates the combinational controls so that a reset landing in
    // MEM_WAIT (or FLUSH, which drives o_pc_inc) takes effect immediately
    assign bus.o_pc_inc  = i_rst_n & w_pc_inc;
    assign bus.o_pc_load = i_rst_n & w_pc_load;
    assign bus.o_pc_addr = i_rst_n ? w_pc_addr : '0;
    assign bus.o_alu_op  = i_rst_n ? w_alu_op  : '0;
    assign bus.o_operand = i_rst_n ? w_operand : '0;
    assign bus.o_reg_we  = i_rst_n & w_reg_we;
    assign bus.o_mem_req = i_rst_n & w_mem_req;
    assign bus.o_mem_we  = i_rst_n & w_mem_we;
    assign bus.o_illegal = i_rst_n & w_illegal;
    assign bus.o_halted  = i_rst_n & w_halted;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef INSTR_DECODER_PERF_EN
    if (1'b1) begin : g_perf_counters
        decoder_perf_counter #(
            .WIDTH (COUNT_WIDTH)
        ) u_retired_cnt (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (w_retire_en),
            .o_count (bus.o_retired)
        );

        decoder_perf_counter #(
            .WIDTH (COUNT_WIDTH)
        ) u_bubbles_cnt (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (w_bubble_en),
            .o_count (bus.o_bubbles)
        );
    end
`else
    if (1'b1) begin : g_no_perf_counters
        logic w_unused_perf;
        assign w_unused_perf = w_retire_en ^ w_bubble_en;
        assign bus.o_retired = '0;
        assign bus.o_bubbles = '0;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_decoder
// Description : Directed self-checking bench for instruction_decoder.
//               Inputs change 1 ns after a rising edge; outputs are sampled
//               on the falling edge. ctl = {pc_inc, pc_load, reg_we,
//               mem_req, mem_we, illegal, halted}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_decoder;

    localparam int CW = 16;
`ifdef INSTR_DECODER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    instruction_decoder_if #(.COUNT_WIDTH(CW)) bus ();

    instruction_decoder #(
        .HALT_WORD   (16'hFFFF),
        .COUNT_WIDTH (CW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    logic [6:0] ctl;
    assign ctl = {bus.o_pc_inc, bus.o_pc_load, bus.o_reg_we, bus.o_mem_req,
                  bus.o_mem_we, bus.o_illegal, bus.o_halted};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle with the given inputs, return at the sampling point
    task automatic cyc(input logic r, input logic [15:0] ins,
                       input logic [15:0] pa, input logic z, input logic rdy);
        @(posedge clk);
        #1;
        rst_n             = r;
        bus.i_instruction = ins;
        bus.i_pc_addr     = pa;
        bus.i_zero        = z;
        bus.i_mem_ready   = rdy;
        @(negedge clk);
    endtask

    task automatic test_reset;
        cyc(1'b0, 16'h1301, 16'h0000, 1'b0, 1'b1);
        if (ctl !== 7'b0000000) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 7'b0000000); end
        checks++;
        if ({bus.o_alu_op, bus.o_operand, bus.o_pc_addr} !== 28'h0) begin errors++; $display("FAIL reset_fields got %h exp 0", {bus.o_alu_op, bus.o_operand, bus.o_pc_addr}); end
        checks++;
        if ({bus.o_retired, bus.o_bubbles} !== 32'h0) begin errors++; $display("FAIL reset_counters got %h exp 0", {bus.o_retired, bus.o_bubbles}); end
        checks++;
        // Release: first cycle is FLUSH
        cyc(1'b1, 16'h1301, 16'h0000, 1'b0, 1'b1);
        if (ctl !== 7'b1000000) begin errors++; $display("FAIL flush_after_reset got %b exp %b", ctl, 7'b1000000); end
        checks++;
        if (bus.o_alu_op !== 4'h0) begin errors++; $display("FAIL flush_alu_op got %h exp 0", bus.o_alu_op); end
        checks++;
    endtask

    task automatic test_alu_nop;
        cyc(1'b1, 16'h1301, 16'h0000, 1'b0, 1'b1);
        if (ctl !== 7'b1010000) begin errors++; $display("FAIL alu_ctl got %b exp %b", ctl, 7'b1010000); end
        checks++;
        if ({bus.o_alu_op, bus.o_operand} !== 12'h301) begin errors++; $display("FAIL alu_fields got %h exp 301", {bus.o_alu_op, bus.o_operand}); end
        checks++;
        cyc(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1);
        if (ctl !== 7'b1000000) begin errors++; $display("FAIL nop_ctl got %b exp %b", ctl, 7'b1000000); end
        checks++;
    endtask

    task automatic test_jump;
        cyc(1'b1, 16'h40FC, 16'h0002, 1'b0, 1'b1);
        if (ctl !== 7'b0100000) begin errors++; $display("FAIL jmp_ctl got %b exp %b", ctl, 7'b0100000); end
        checks++;
        if (bus.o_pc_addr !== 16'hFFFE) begin errors++; $display("FAIL jmp_target got %h exp FFFE", bus.o_pc_addr); end
        checks++;
        // Stale ALU word must be ignored in FLUSH
        cyc(1'b1, 16'h1301, 16'h0003, 1'b0, 1'b1);
        if (ctl !== 7'b1000000) begin errors++; $display("FAIL jmp_flush got %b exp %b", ctl, 7'b1000000); end
        checks++;
        cyc(1'b1, 16'h1200, 16'hFFFE, 1'b0, 1'b1);
        if (ctl !== 7'b1010000 || bus.o_alu_op !== 4'h2) begin errors++; $display("FAIL jmp_target_exec got %b/%h exp %b/2", ctl, bus.o_alu_op, 7'b1010000); end
        checks++;
    endtask

    task automatic test_branch;
        cyc(1'b1, 16'h5005, 16'h0010, 1'b0, 1'b1);
        if (ctl !== 7'b1000000) begin errors++; $display("FAIL bz_untaken got %b exp %b", ctl, 7'b1000000); end
        checks++;
        cyc(1'b1, 16'h5005, 16'h0011, 1'b1, 1'b1);
        if (ctl !== 7'b0100000) begin errors++; $display("FAIL bz_taken got %b exp %b", ctl, 7'b0100000); end
        checks++;
        if (bus.o_pc_addr !== 16'h0016) begin errors++; $display("FAIL bz_target got %h exp 0016", bus.o_pc_addr); end
        checks++;
        cyc(1'b1, 16'h0000, 16'h0012, 1'b1, 1'b1);
        if (ctl !== 7'b1000000) begin errors++; $display("FAIL bz_flush got %b exp %b", ctl, 7'b1000000); end
        checks++;
        cyc(1'b1, 16'h60FF, 16'h0016, 1'b1, 1'b1);
        if (ctl !== 7'b1000000) begin errors++; $display("FAIL bnz_untaken got %b exp %b", ctl, 7'b1000000); end
        checks++;
        cyc(1'b1, 16'h6080, 16'h0100, 1'b0, 1'b1);
        if (ctl !== 7'b0100000 || bus.o_pc_addr !== 16'h0080) begin errors++; $display("FAIL bnz_taken got %b/%h exp %b/0080", ctl, bus.o_pc_addr, 7'b0100000); end
        checks++;
        cyc(1'b1, 16'h0000, 16'h0101, 1'b0, 1'b1);
        if (ctl !== 7'b1000000) begin errors++; $display("FAIL bnz_flush got %b exp %b", ctl, 7'b1000000); end
        checks++;
    endtask

    task automatic test_load_stall;
        cyc(1'b1, 16'h2010, 16'h0080, 1'b0, 1'b0);
        if (ctl !== 7'b0001000) begin errors++; $display("FAIL load_issue got %b exp %b", ctl, 7'b0001000); end
        checks++;
        if (bus.o_retired !== (PERF ? 16'd8 : 16'd0) || bus.o_bubbles !== (PERF ? 16'd4 : 16'd0)) begin
            errors++; $display("FAIL counters_pre_load got %0d/%0d exp %0d/%0d", bus.o_retired, bus.o_bubbles, PERF ? 8 : 0, PERF ? 4 : 0);
        end
        checks++;
        // Input word changes during the wait; latched load must drive controls
        cyc(1'b1, 16'h1301, 16'h0081, 1'b0, 1'b0);
        if (ctl !== 7'b0001000 || {bus.o_alu_op, bus.o_operand} !== 12'h010) begin errors++; $display("FAIL load_wait1 got %b/%h exp %b/010", ctl, {bus.o_alu_op, bus.o_operand}, 7'b0001000); end
        checks++;
        cyc(1'b1, 16'h1301, 16'h0081, 1'b0, 1'b0);
        if (ctl !== 7'b0001000) begin errors++; $display("FAIL load_wait2 got %b exp %b", ctl, 7'b0001000); end
        checks++;
        cyc(1'b1, 16'h1301, 16'h0081, 1'b0, 1'b1);
        if (ctl !== 7'b1011000) begin errors++; $display("FAIL load_done got %b exp %b", ctl, 7'b1011000); end
        checks++;
        // No flush on exit: next word executes immediately
        cyc(1'b1, 16'h3020, 16'h0081, 1'b0, 1'b1);
        if (ctl !== 7'b1001100) begin errors++; $display("FAIL store_ready got %b exp %b", ctl, 7'b1001100); end
        checks++;
        if (bus.o_retired !== (PERF ? 16'd9 : 16'd0) || bus.o_bubbles !== (PERF ? 16'd7 : 16'd0)) begin
            errors++; $display("FAIL counters_post_load got %0d/%0d exp %0d/%0d", bus.o_retired, bus.o_bubbles, PERF ? 9 : 0, PERF ? 7 : 0);
        end
        checks++;
    endtask

    task automatic test_illegal_halt;
        cyc(1'b1, 16'h7123, 16'h0082, 1'b0, 1'b1);
        if (ctl !== 7'b1000010) begin errors++; $display("FAIL illegal_ctl got %b exp %b", ctl, 7'b1000010); end
        checks++;
        cyc(1'b1, 16'h0000, 16'h0083, 1'b0, 1'b1);
        if (ctl !== 7'b1000000) begin errors++; $display("FAIL illegal_pulse got %b exp %b", ctl, 7'b1000000); end
        checks++;
        if (bus.o_retired !== (PERF ? 16'd11 : 16'd0)) begin errors++; $display("FAIL retired_count got %0d exp %0d", bus.o_retired, PERF ? 11 : 0); end
        checks++;
        cyc(1'b1, 16'hFFFF, 16'h0084, 1'b0, 1'b1);
        if (ctl !== 7'b0000000) begin errors++; $display("FAIL halt_decode got %b exp %b", ctl, 7'b0000000); end
        checks++;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 16'h1301, 16'h0084, 1'b1, 1'b1);
            if (ctl !== 7'b0000001) begin errors++; $display("FAIL halt_hold%0d got %b exp %b", i, ctl, 7'b0000001); end
            checks++;
        end
    endtask

    task automatic test_reset_mid_wait;
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        if (ctl !== 7'b0000000) begin errors++; $display("FAIL halt_reset got %b exp %b", ctl, 7'b0000000); end
        checks++;
        cyc(1'b1, 16'h1301, 16'h0000, 1'b0, 1'b0);
        cyc(1'b1, 16'h1301, 16'h0000, 1'b0, 1'b0);
        if (ctl !== 7'b1010000) begin errors++; $display("FAIL restart_alu got %b exp %b", ctl, 7'b1010000); end
        checks++;
        cyc(1'b1, 16'h2044, 16'h0001, 1'b0, 1'b0);
        cyc(1'b1, 16'h1301, 16'h0002, 1'b0, 1'b0);
        if (ctl !== 7'b0001000) begin errors++; $display("FAIL wait_before_reset got %b exp %b", ctl, 7'b0001000); end
        checks++;
        #1 rst_n = 1'b0;
        #1;
        if (bus.o_mem_req !== 1'b0 || ctl !== 7'b0000000) begin errors++; $display("FAIL async_abort got %b exp %b", ctl, 7'b0000000); end
        checks++;
        cyc(1'b0, 16'h1301, 16'h0002, 1'b0, 1'b1);
        cyc(1'b1, 16'h2044, 16'h0000, 1'b0, 1'b1);
        if (ctl !== 7'b1000000) begin errors++; $display("FAIL flush_after_abort got %b exp %b", ctl, 7'b1000000); end
        checks++;
        cyc(1'b1, 16'h1301, 16'h0000, 1'b0, 1'b1);
        if (ctl !== 7'b1010000 || bus.o_alu_op !== 4'h3) begin errors++; $display("FAIL restart_decode got %b/%h exp %b/3", ctl, bus.o_alu_op, 7'b1010000); end
        checks++;
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        rst_n             = 1'b0;
        bus.i_instruction = 16'h0000;
        bus.i_pc_addr     = 16'h0000;
        bus.i_zero        = 1'b0;
        bus.i_mem_ready   = 1'b0;

        test_reset;
        test_alu_nop;
        test_jump;
        test_branch;
        test_load_stall;
        test_illegal_halt;
        test_reset_mid_wait;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
